// File: rtl/ctrl_pipe.sv
// Control-bundle pipeline D -> E -> M -> W... with bubble/flush handling and a multicycle-op FSM.
// Optional perf counters are built when CTRL_PIPE_PERF_EN is defined.

module ctrl_pipe_stage #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          bubble,
    input  logic [CW-1:0] ctrlIn,
    input  logic          vldIn,
    output logic [CW-1:0] ctrlOut,
    output logic          vldOut
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrlOut <= '0;
            vldOut  <= 1'b0;
        end else if (bubble) begin
            ctrlOut <= '0;
            vldOut  <= 1'b0;
        end else begin
            ctrlOut <= ctrlIn;
            vldOut  <= vldIn;
        end
    end
endmodule

module ctrl_pipe #(
    parameter int CW        = 16,
    parameter int NSTAGES   = 3,
    parameter int MC_CYCLES = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CW-1:0]         ctrl_d,
    input  logic                  valid_d,
    input  logic                  mc_d,
    input  logic                  stall_e,
    input  logic                  flush_e,
    output logic [NSTAGES*CW-1:0] ctrl_q,
    output logic [NSTAGES-1:0]    valid_q,
    output logic                  mc_busy,
    output logic                  mc_done,
    output logic                  stall_req,
    output logic [31:0]           perf_stall,
    output logic [31:0]           perf_bub
);
    localparam int CNTW = $clog2(MC_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} mcState_t;

    mcState_t                     state;
    logic [CNTW-1:0]              cnt;
    logic [NSTAGES-1:0][CW-1:0]   ctrlPipe;
    logic [NSTAGES-1:0]           vldPipe;
    logic [CW-1:0]                ctrlE;
    logic                         vldE;
    logic                         mcE;
    logic                         holdE;
    logic                         bubbleIns;

    assign stall_req = ((state == IDLE) && vldE && mcE) || (state == BUSY);
    assign holdE     = stall_e | stall_req;
    assign bubbleIns = holdE | flush_e;
    assign mc_busy   = (state == BUSY);
    assign mc_done   = (state == DONE);

    assign ctrlPipe[0] = ctrlE;
    assign vldPipe[0]  = vldE;
    assign ctrl_q      = ctrlPipe;
    assign valid_q     = vldPipe;

    // E: flush beats hold beats load
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrlE <= '0;
            vldE  <= 1'b0;
            mcE   <= 1'b0;
        end else if (flush_e) begin
            ctrlE <= '0;
            vldE  <= 1'b0;
            mcE   <= 1'b0;
        end else if (!holdE) begin
            ctrlE <= ctrl_d;
            vldE  <= valid_d;
            mcE   <= mc_d;
        end
    end

    // Later stages never stall; only stage 1 can take a bubble
    for (genvar s = 1; s < NSTAGES; s++) begin : gStage
        ctrl_pipe_stage #(.CW(CW)) uStage (
            .clk     (clk),
            .rst     (rst),
            .bubble  ((s == 1) ? bubbleIns : 1'b0),
            .ctrlIn  (ctrlPipe[s-1]),
            .vldIn   (vldPipe[s-1]),
            .ctrlOut (ctrlPipe[s]),
            .vldOut  (vldPipe[s])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (vldE && mcE && !flush_e) begin
                        state <= BUSY;
                        cnt   <= CNTW'(MC_CYCLES - 1);
                    end
                end
                BUSY: begin
                    if (flush_e) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == '0) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (flush_e) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (!stall_e) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef CTRL_PIPE_PERF_EN
    logic [31:0] perfStallQ;
    logic [31:0] perfBubQ;

    // Saturating event counters, cleared only by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perfStallQ <= '0;
            perfBubQ   <= '0;
        end else begin
            if (stall_req && (perfStallQ != 32'hFFFF_FFFF))
                perfStallQ <= perfStallQ + 32'd1;
            if (bubbleIns && (perfBubQ != 32'hFFFF_FFFF))
                perfBubQ <= perfBubQ + 32'd1;
        end
    end

    assign perf_stall = perfStallQ;
    assign perf_bub   = perfBubQ;
`else
    assign perf_stall = 32'd0;
    assign perf_bub   = 32'd0;
`endif

endmodule
